spi_target: RTL



---
 rtl/spi_target.sv | 98 +++++++++
 1 files changed

// File: rtl/spi_target.sv
// spi_target: mode 0 SPI responder clocked by e, single-entry RX/TX buffers; SPI_TARGET_MISO_HIZ_EN floats miso while idle.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       e,
  input  logic       _reset,
  input  logic       _ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_re,
  output logic       overrun,
  output logic       busy
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
  logic                   ss_hist_q, sck_hist_q;
  logic [0:0]             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic [7:0]             tx_buf_q, tx_buf_d, tx_sh_q, tx_sh_d;
  logic                   tx_empty_q, tx_empty_d;
  logic                   ss_s, sck_s, mosi_s, act;
  logic                   ss_fall, ss_rise, sck_rise, sck_fall, done, reload;
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign act      = state_q == ACTIVE;
  assign ss_fall  = ss_hist_q & ~ss_s;
  assign ss_rise  = ~ss_hist_q & ss_s;
  assign sck_rise = act & sck_s & ~sck_hist_q;
  assign sck_fall = act & ~sck_s & sck_hist_q;
  assign done     = sck_rise & (cnt_q == 3'd7);
  // a byte boundary reloads the shifter; a coincident tx_we bypasses the buffer
  assign reload   = ss_fall | (sck_fall & (cnt_q == 3'd0));
  always_comb begin
    state_d    = ss_fall ? ACTIVE : ss_rise ? IDLE : state_q;
    cnt_d      = (ss_fall | ss_rise) ? 3'd0 : sck_rise ? cnt_q + 3'd1 : cnt_q;
    rx_sh_d    = sck_rise ? {rx_sh_q[6:0], mosi_s} : rx_sh_q;
    rx_data_d  = done ? rx_sh_d : rx_data_q;
    rx_valid_d = done | (rx_valid_q & ~rx_re);
    overrun_d  = rx_re ? 1'b0 : overrun_q | (done & rx_valid_q);
    tx_buf_d   = tx_we ? tx_data : tx_buf_q;
    tx_empty_d = reload | (tx_empty_q & ~tx_we);
    tx_sh_d    = reload ? (tx_we ? tx_data : tx_empty_q ? 8'hFF : tx_buf_q)
               : sck_fall ? {tx_sh_q[6:0], 1'b1} : tx_sh_q;
  end
  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      ss_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_hist_q   <= 1'b1;
      sck_hist_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rx_sh_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_buf_q    <= 8'hFF;
      tx_empty_q  <= 1'b1;
      tx_sh_q     <= 8'hFF;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], _ss};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_hist_q   <= ss_s;
      sck_hist_q  <= sck_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      tx_buf_q    <= tx_buf_d;
      tx_empty_q  <= tx_empty_d;
      tx_sh_q     <= tx_sh_d;
    end
  end
`ifdef SPI_TARGET_MISO_HIZ_EN
  assign miso = act ? tx_sh_q[7] : 1'bz;
`else
  assign miso = act & tx_sh_q[7];
`endif
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign tx_empty = tx_empty_q;
  assign busy     = act;
endmodule
